// File: rtl/peripheral_screen_capture.sv
// Snoops a 32x32 HUB75 bus, rebuilds the displayed frame into a row buffer and
// lets the CPU read it back one RGB bit-plane word at a time.
module peripheral_screen_capture #(
  parameter int sync_stages = 2,
  parameter int cols        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] d_in,
  input  logic [2:0]  addr,
  output logic [31:0] d_out,
  input  logic        clk_screen,
  input  logic        R0,
  input  logic        G0,
  input  logic        B0,
  input  logic        R1,
  input  logic        G1,
  input  logic        B1,
  input  logic        blank,
  input  logic        latch,
  input  logic [4:0]  row
);

  localparam int n_pins = 14;
  localparam logic [5:0] cnt_full = 6'(cols);
  localparam logic [5:0] cnt_sat  = 6'(cols + 1);

  logic [n_pins-1:0] pins;
  logic [n_pins-1:0] sync_reg [sync_stages];
  logic [n_pins-1:0] s_pins;
  logic              s_clk, s_latch, s_blank;
  logic [5:0]        s_pix;
  logic [4:0]        s_row;
  logic [1:0]        prev_reg;
  logic              clk_rise, latch_rise;

  logic              enable_reg, frame_done_reg, len_err_reg;
  logic [31:0]       row_valid_reg;
  logic [3:0]        last_row_reg;
  logic [7:0]        frame_cnt_reg;
  logic [5:0]        col_cnt_reg, col_cnt_next;
  logic [5:0][31:0]  shift_reg, shift_next;
  logic [4:0]        row_sel_reg;
  logic [1:0]        plane_sel_reg;
  logic [31:0]       d_out_reg;

  logic              shift_fire, commit_fire, commit_ok, frame_end;
  logic [3:0]        commit_row;
  logic [31:0]       row_set;
  logic              ctrl_wr, sel_wr, rd_en, clr_flags, clr_valid;
  logic [95:0]       upper_mem [16];
  logic [95:0]       lower_mem [16];
  logic [95:0]       rd_row;
  logic [31:0]       data_word, status_word;
  logic              unused_ok;

  // Pin vector order: pix[0..5] = R0,G0,B0,R1,G1,B1.
  assign pins = {row, latch, blank, B1, G1, R1, B0, G0, R0, clk_screen};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < sync_stages; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= pins;
      for (int i = 1; i < sync_stages; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign s_pins     = sync_reg[sync_stages-1];
  assign s_clk      = s_pins[0];
  assign s_pix      = s_pins[6:1];
  assign s_blank    = s_pins[7];
  assign s_latch    = s_pins[8];
  assign s_row      = s_pins[13:9];
  assign clk_rise   = s_clk & ~prev_reg[0];
  assign latch_rise = s_latch & ~prev_reg[1];

  assign shift_fire  = enable_reg & clk_rise;
  assign commit_fire = enable_reg & latch_rise;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_shift
      assign shift_next[gi] = shift_fire ? {shift_reg[gi][30:0], s_pix[gi]} : shift_reg[gi];
    end
  endgenerate

  // A shift and a commit in the same cycle: the commit sees the shifted state.
  assign col_cnt_next = (shift_fire && col_cnt_reg != cnt_sat) ? col_cnt_reg + 6'd1 : col_cnt_reg;
  assign commit_ok    = commit_fire && (col_cnt_next == cnt_full);
  assign commit_row   = s_row[3:0];
  assign frame_end    = commit_ok && (commit_row == 4'hf);
  assign row_set      = commit_ok ? ((32'd1 << commit_row) | (32'd1 << (5'(commit_row) + 5'd16)))
                                  : 32'd0;

  assign ctrl_wr   = cs & wr & (addr == 3'd0);
  assign sel_wr    = cs & wr & (addr == 3'd2);
  assign rd_en     = cs & rd;
  assign clr_flags = ctrl_wr & d_in[1];
  assign clr_valid = ctrl_wr & d_in[2];

  always_ff @(posedge clk) begin
    if (commit_ok) begin
      upper_mem[commit_row] <= {shift_next[2], shift_next[1], shift_next[0]};
      lower_mem[commit_row] <= {shift_next[5], shift_next[4], shift_next[3]};
    end
  end

  assign rd_row = row_sel_reg[4] ? lower_mem[row_sel_reg[3:0]] : upper_mem[row_sel_reg[3:0]];

  always_comb begin
    data_word = 32'd0;
    if (row_valid_reg[row_sel_reg]) begin
      case (plane_sel_reg)
        2'd0:    data_word = rd_row[31:0];
        2'd1:    data_word = rd_row[63:32];
        2'd2:    data_word = rd_row[95:64];
        default: data_word = 32'd0;
      endcase
    end
  end

  assign status_word = {10'd0, col_cnt_reg, frame_cnt_reg, last_row_reg,
                        enable_reg, s_blank, len_err_reg, frame_done_reg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_reg       <= '0;
      shift_reg      <= '0;
      col_cnt_reg    <= '0;
      enable_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      len_err_reg    <= 1'b0;
      row_valid_reg  <= '0;
      last_row_reg   <= '0;
      frame_cnt_reg  <= '0;
      row_sel_reg    <= '0;
      plane_sel_reg  <= '0;
      d_out_reg      <= '0;
    end else begin
      prev_reg  <= {s_latch, s_clk};
      shift_reg <= shift_next;

      if ((ctrl_wr && !d_in[0]) || commit_fire) col_cnt_reg <= '0;
      else                                      col_cnt_reg <= col_cnt_next;

      if (ctrl_wr) enable_reg <= d_in[0];

      // Clears from CTRL win over a set from a simultaneous commit.
      if (clr_flags)      frame_done_reg <= 1'b0;
      else if (frame_end) frame_done_reg <= 1'b1;

      if (clr_flags)                      len_err_reg <= 1'b0;
      else if (commit_fire && !commit_ok) len_err_reg <= 1'b1;

      if (clr_valid) row_valid_reg <= '0;
      else           row_valid_reg <= row_valid_reg | row_set;

      if (commit_ok) last_row_reg  <= commit_row;
      if (frame_end) frame_cnt_reg <= frame_cnt_reg + 8'd1;

      if (sel_wr) begin
        row_sel_reg   <= d_in[4:0];
        plane_sel_reg <= d_in[9:8];
      end

      if (rd_en) begin
        case (addr)
          3'd1:    d_out_reg <= status_word;
          3'd3:    d_out_reg <= data_word;
          3'd4:    d_out_reg <= row_valid_reg;
          default: d_out_reg <= 32'd0;
        endcase
      end
    end
  end

  assign d_out = d_out_reg;

  assign unused_ok = ^{d_in[31:10], d_in[7:5], s_row[4]};

endmodule

// File: tb/tb_peripheral_screen_capture.sv
// Randomized scoreboard bench for peripheral_screen_capture against a frame-level
// reference model (line words, row-valid mask, flags and counters).
module tb_peripheral_screen_capture;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [31:0] d_in = '0;
  logic [2:0]  addr = '0;
  logic [31:0] d_out;
  logic        clk_screen = 1'b0;
  logic        R0 = 1'b0, G0 = 1'b0, B0 = 1'b0, R1 = 1'b0, G1 = 1'b0, B1 = 1'b0;
  logic        blank = 1'b0, latch = 1'b0;
  logic [4:0]  row = '0;

  always #5 clk = ~clk;

  peripheral_screen_capture #(.sync_stages(SYNC), .cols(32)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .d_in(d_in), .addr(addr),
    .d_out(d_out), .clk_screen(clk_screen),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .blank(blank), .latch(latch), .row(row)
  );

  int n_check = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  // Reference model: what the frame buffer and registers should hold.
  logic [31:0] mdl_buf [32][3];
  logic [31:0] mdl_valid = '0;
  logic        mdl_done = 0, mdl_len = 0, mdl_en = 0, mdl_blank = 0;
  logic [7:0]  mdl_fcnt = '0;
  logic [3:0]  mdl_last = '0;
  int          mdl_col = 0;
  logic [4:0]  mdl_rsel = '0;
  logic [1:0]  mdl_psel = '0;

  function automatic logic [31:0] exp_status();
    return {10'd0, 6'(mdl_col), mdl_fcnt, mdl_last, mdl_en, mdl_blank, mdl_len, mdl_done};
  endfunction

  function automatic logic [31:0] exp_data();
    if (!mdl_valid[mdl_rsel] || mdl_psel == 2'd3) return 32'd0;
    return mdl_buf[mdl_rsel][mdl_psel];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
    addr = a; d_in = v; cs = 1; wr = 1;
    tick(1);
    cs = 0; wr = 0;
    if (a == 3'd0) begin
      if (!v[0]) mdl_col = 0;
      mdl_en = v[0];
      if (v[1]) begin mdl_done = 0; mdl_len = 0; end
      if (v[2]) mdl_valid = '0;
    end else if (a == 3'd2) begin
      mdl_rsel = v[4:0];
      mdl_psel = v[9:8];
    end
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] e, input string nm);
    addr = a; cs = 1; rd = 1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick(1);
    cs = 0; rd = 0;
  endtask

  task automatic read_data(input logic [4:0] r, input logic [1:0] p, input string nm);
    bus_write(3'd2, {22'd0, p, 3'd0, r});
    bus_read(3'd3, exp_data(), nm);
  endtask

  task automatic shift_one(input logic [5:0] pix, input bit with_latch, input logic [3:0] r);
    {B1, G1, R1, B0, G0, R0} = pix;
    clk_screen = 0;
    tick(2);
    if (with_latch) begin
      row = {1'($urandom_range(0, 1)), r};
      latch = 1;
    end
    clk_screen = 1;
    tick(2);
    if (mdl_en && mdl_col < 33) mdl_col++;
  endtask

  // A completed line of 32 shifts stores each channel word as driven:
  // the first bit shifted lands in column 31.
  task automatic model_commit(input logic [3:0] r, input logic [5:0][31:0] w);
    if (!mdl_en) return;
    if (mdl_col == 32) begin
      for (int k = 0; k < 3; k++) begin
        mdl_buf[r][k]      = w[k];
        mdl_buf[r + 16][k] = w[3 + k];
      end
      mdl_valid[r]      = 1'b1;
      mdl_valid[r + 16] = 1'b1;
      mdl_last = r;
      if (r == 4'hf) begin mdl_done = 1; mdl_fcnt++; end
    end else begin
      mdl_len = 1;
    end
    mdl_col = 0;
  endtask

  task automatic send_line(input logic [5:0][31:0] w, input int n, input logic [3:0] r,
                           input bit merged);
    logic [5:0] pix;
    blank = 1'($urandom_range(0, 1));
    mdl_blank = blank;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 6; c++) pix[c] = (i < 32) ? w[c][31 - i] : 1'b0;
      shift_one(pix, merged && (i == n - 1), r);
    end
    if (!merged) begin
      clk_screen = 0;
      row = {1'($urandom_range(0, 1)), r};
      tick(2);
      latch = 1;
      tick(2);
    end
    latch = 0;
    clk_screen = 0;
    tick(SYNC + 2);
    model_commit(r, w);
  endtask

  // Monitor: checks d_out after every read edge, and holds it at 0 under reset.
  initial begin
    logic [31:0] e;
    string       nm;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (!rst) begin
        n_check++;
        if (d_out !== 32'd0) begin
          n_fail++;
          $display("FAIL reset_dout: got %h expected 00000000", d_out);
        end
      end else if (cs && rd) begin
        n_check++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_read: got %h expected no read", d_out);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (d_out !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, d_out, e);
          end else begin
            $display("read %-16s d_out=%h", nm, d_out);
          end
        end
      end
    end
  end

  initial begin
    logic [5:0][31:0] w;
    int               n, k, op;

    tick(3);
    rst = 1;
    tick(2);
    bus_read(3'd1, exp_status(), "reset_status");
    bus_read(3'd4, 32'd0, "reset_rowvalid");
    read_data(5'd0, 2'd0, "reset_data");
    bus_write(3'd0, 32'd1);

    // Single marker bit in the first shifted position of upper red.
    w = '0;
    w[0] = 32'h8000_0000;
    send_line(w, 32, 4'd3, 0);
    read_data(5'd3, 2'd0, "row3_red");
    read_data(5'd19, 2'd0, "row19_red");
    bus_read(3'd4, mdl_valid, "rowvalid_3_19");

    // Full lower green line on row 15 ends a frame.
    w = '0;
    w[4] = 32'hFFFF_FFFF;
    send_line(w, 32, 4'd15, 0);
    bus_read(3'd1, exp_status(), "status_frame1");
    read_data(5'd31, 2'd1, "row31_green");

    // Short line: length error, nothing stored.
    for (int c = 0; c < 6; c++) w[c] = $urandom;
    send_line(w, 31, 4'd5, 0);
    bus_read(3'd1, exp_status(), "status_len_err");
    bus_read(3'd4, mdl_valid, "rowvalid_no_r5");
    bus_write(3'd0, 32'd3);
    bus_read(3'd1, exp_status(), "status_cleared");

    // DATA read on the same edge as the commit of the row being read.
    read_data(5'd3, 2'd0, "row3_before");
    w = '0;
    w[0] = 32'h0000_FFFF;
    for (int i = 0; i < 32; i++) shift_one({5'd0, w[0][31 - i]}, 0, 4'd3);
    clk_screen = 0;
    row = 5'd3;
    tick(2);
    latch = 1;
    tick(SYNC);
    addr = 3'd3; cs = 1; rd = 1;
    exp_q.push_back(exp_data());
    name_q.push_back("collide_old");
    tick(1);
    model_commit(4'd3, w);
    exp_q.push_back(exp_data());
    name_q.push_back("collide_new");
    tick(1);
    cs = 0; rd = 0; latch = 0;
    tick(SYNC + 2);

    // Random lines, lengths, merged shift/latch edges and readback.
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < 6; c++) w[c] = $urandom;
      k = $urandom_range(0, 9);
      n = (k < 7) ? 32 : (k == 7) ? 31 : (k == 8) ? 33 : $urandom_range(1, 30);
      send_line(w, n, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
      for (int j = 0; j < 2; j++) begin
        op = $urandom_range(0, 5);
        if (op < 3)       read_data(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), "rand_data");
        else if (op == 3) bus_read(3'd1, exp_status(), "rand_status");
        else if (op == 4) bus_read(3'd4, mdl_valid, "rand_rowvalid");
        else              bus_read(3'(5 + $urandom_range(0, 2)), 32'd0, "unmapped");
      end
      if (t % 10 == 9)
        bus_write(3'd0, {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
    end

    // Asynchronous reset in the middle of a line.
    blank = 0;
    mdl_blank = 0;
    bus_write(3'd0, 32'd1);
    w = '1;
    send_line(w, 32, 4'd7, 0);
    blank = 0;
    mdl_blank = 0;
    tick(SYNC + 1);
    bus_read(3'd4, mdl_valid, "pre_reset_valid");
    for (int i = 0; i < 10; i++) shift_one(6'h3f, 0, 4'd0);
    #2 rst = 0;
    mdl_en = 0; mdl_done = 0; mdl_len = 0; mdl_valid = '0; mdl_fcnt = '0;
    mdl_last = '0; mdl_col = 0; mdl_rsel = '0; mdl_psel = '0;
    tick(3);
    rst = 1;
    tick(SYNC + 1);
    bus_read(3'd1, exp_status(), "post_rst_status");
    bus_read(3'd4, 32'd0, "post_rst_valid");
    send_line(w, 32, 4'd3, 0);
    blank = 0;
    mdl_blank = 0;
    tick(SYNC + 1);
    bus_read(3'd1, exp_status(), "disabled_status");
    bus_read(3'd4, mdl_valid, "disabled_valid");

    // 300 frame-ending lines: frame counter wraps to 300 mod 256.
    bus_write(3'd0, 32'd1);
    for (int f = 0; f < 300; f++) begin
      for (int c = 0; c < 6; c++) w[c] = $urandom;
      send_line(w, 32, 4'd15, 0);
    end
    bus_read(3'd1, exp_status(), "status_300");
    bus_read(3'd1, {16'd0, 8'd44, 8'h00} | (exp_status() & 32'hFFFF_00FF), "frame_cnt_44");
    read_data(5'd15, 2'd2, "row15_blue");
    read_data(5'd31, 2'd0, "row31_red");

    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
